uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter among NUM_REQ requesters. Round-robin arbitration, one frame per grant.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rr_arbiter.sv | 96 +++++++++
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - parity codes as seen on the transmitter's par input
//   - scheduler FSM state encoding
//   - frame_len(): number of bit periods one frame occupies on the line
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE     = 2'd0;
    localparam logic [1:0] PAR_ODD      = 2'd1;
    localparam logic [1:0] PAR_EVEN     = 2'd2;
    localparam logic [1:0] PAR_NONE_ALT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } sched_state_e;

    // start + data bits + optional parity bit + stop bits; spans 9..12
    function automatic logic [3:0] frame_len(input logic [1:0] par,
                                             input logic       d_num,
                                             input logic       s_num);
        logic [3:0] par_bits;
        case (par)
            PAR_ODD, PAR_EVEN:      par_bits = 4'd1;
            PAR_NONE, PAR_NONE_ALT: par_bits = 4'd0;
            default:                par_bits = 4'd0;
        endcase
        return 4'd1 + (d_num ? 4'd8 : 4'd7) + par_bits + (s_num ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
// Picks one requester out of valid_i. Default: round-robin, the search
// starts at the internal pointer, which moves to winner+1 on every grant.
// Build option UART_SCHED_FIXED_PRIO_EN: lowest valid index always wins and
// the pointer stays at 0.
// Ports:
//   clk_tx    in   clock (rising edge)
//   reset_n   in   asynchronous active-low reset (pointer -> 0)
//   valid_i   in   [NUM_REQ] request vector
//   grant_i   in   winner was accepted this cycle, advance pointer
//   win_oh_o  out  [NUM_REQ] one-hot winner (all zero if no request)
//   win_idx_o out  [ID_W] winner index
//   any_o     out  at least one request present
// -----------------------------------------------------------------------------
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_tx,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic                       grant_i,
    output logic [NUM_REQ-1:0]         win_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] win_idx_o,
    output logic                       any_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W:0]      cand_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               found_s;
    logic [NUM_REQ-1:0] win_oh_s;

    // Search from the pointer upward with wrap; first valid channel wins.
    always_comb begin
        cand_s    = '0;
        win_idx_s = '0;
        found_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && valid_i[cand_s[ID_W-1:0]]) begin
                found_s   = 1'b1;
                win_idx_s = cand_s[ID_W-1:0];
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s) begin
            win_oh_s = NUM_REQ'(1) << win_idx_s;
        end else begin
            win_oh_s = '0;
        end
    end

    // Next pointer: one past the winner, wrapping to 0 (fixed build keeps 0).
    always_comb begin
        ptr_d = ptr_q;
        if (grant_i) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
            ptr_d = '0;
`else
            if (win_idx_s == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx_s + ID_W'(1);
            end
`endif
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_tx or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign win_oh_o  = win_oh_s;
    assign win_idx_o = win_idx_s;
    assign any_o     = found_s;

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ requesters, one frame per grant.
// The transmitter has no busy flag, so the frame length is counted here:
// IDLE (accept) -> LOAD (tx_en pulse) -> SEND (FRAME_LEN cycles) -> GAP
// (GAP_CYCLES cycles, skipped when 0) -> IDLE.
// Build option UART_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index)
// instead of round-robin (see uart_rr_arbiter).
// Ports:
//   clk_tx      in   transmit bit clock, rising edge
//   reset_n     in   asynchronous active-low reset, aborts any frame
//   req_valid   in   [NUM_REQ] per-channel request
//   req_data    in   [8*NUM_REQ] channel i byte at [8i+7:8i]
//   req_par     in   [2*NUM_REQ] channel i parity code at [2i+1:2i]
//   req_d_num   in   [NUM_REQ] 1 = 8 data bits, 0 = 7
//   req_s_num   in   [NUM_REQ] 1 = 2 stop bits, 0 = 1
//   req_ready   out  [NUM_REQ] one-hot accept pulse
//   tx_en       out  one-cycle transmitter start pulse
//   tx_data/tx_par/tx_d_num/tx_s_num out  frame config, stable until next accept
//   busy        out  state != IDLE
//   grant_id    out  [ID_W] channel owning the current frame
//   frame_done  out  pulse on the last SEND cycle
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk_tx,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [2*NUM_REQ-1:0]       req_par,
    input  logic [NUM_REQ-1:0]         req_d_num,
    input  logic [NUM_REQ-1:0]         req_s_num,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_en,
    output logic [7:0]                 tx_data,
    output logic [1:0]                 tx_par,
    output logic                       tx_d_num,
    output logic                       tx_s_num,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic               tx_en_q;
    logic [7:0]         tx_data_q;
    logic [1:0]         tx_par_q;
    logic               tx_d_num_q;
    logic               tx_s_num_q;
    logic [ID_W-1:0]    grant_id_q;

    logic [NUM_REQ-1:0] win_oh_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               any_s;
    logic               accept_s;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_tx    (clk_tx),
        .reset_n   (reset_n),
        .valid_i   (req_valid),
        .grant_i   (accept_s),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .any_o     (any_s)
    );

    // Accept only in IDLE; gating with reset_n keeps req_ready low during reset.
    assign accept_s  = (state_q == IDLE) && any_s && reset_n;
    assign req_ready = win_oh_s & {NUM_REQ{accept_s}};

    // Next-state and counter logic. One counter serves both SEND and GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SEND;
                cnt_d   = frame_len(tx_par_q, tx_d_num_q, tx_s_num_q);
            end
            SEND: begin
                if (cnt_q == 4'd1) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = 4'(GAP_CYCLES);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_tx or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the winner's frame config on accept; held until the next accept.
    always_ff @(posedge clk_tx or negedge reset_n) begin
        if (!reset_n) begin
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_par_q   <= 2'd0;
            tx_d_num_q <= 1'b0;
            tx_s_num_q <= 1'b0;
            grant_id_q <= '0;
        end else begin
            tx_en_q <= accept_s;
            if (accept_s) begin
                tx_data_q  <= req_data[{win_idx_s, 3'b000} +: 8];
                tx_par_q   <= req_par[{win_idx_s, 1'b0} +: 2];
                tx_d_num_q <= req_d_num[win_idx_s];
                tx_s_num_q <= req_s_num[win_idx_s];
                grant_id_q <= win_idx_s;
            end else begin
                tx_data_q  <= tx_data_q;
                tx_par_q   <= tx_par_q;
                tx_d_num_q <= tx_d_num_q;
                tx_s_num_q <= tx_s_num_q;
                grant_id_q <= grant_id_q;
            end
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign tx_par     = tx_par_q;
    assign tx_d_num   = tx_d_num_q;
    assign tx_s_num   = tx_s_num_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == SEND) && (cnt_q == 4'd1);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler (default round-robin build,
// NUM_REQ=4, GAP_CYCLES=1). A timeline model predicts, per cycle, which
// channel is accepted and when tx_en / frame_done / busy occur, from the
// accept cycle plus frame length arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 1;

    logic               clk_tx = 1'b0;
    logic               reset_n;
    logic [N-1:0]       req_valid;
    logic [8*N-1:0]     req_data;
    logic [2*N-1:0]     req_par;
    logic [N-1:0]       req_d_num;
    logic [N-1:0]       req_s_num;
    logic [N-1:0]       req_ready;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic [1:0]         tx_par;
    logic               tx_d_num;
    logic               tx_s_num;
    logic               busy;
    logic [1:0]         grant_id;
    logic               frame_done;

    always #5 clk_tx = ~clk_tx;

    uart_tx_scheduler #(
        .NUM_REQ    (N),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_tx     (clk_tx),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_par    (req_par),
        .req_d_num  (req_d_num),
        .req_s_num  (req_s_num),
        .req_ready  (req_ready),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_par     (tx_par),
        .tx_d_num   (tx_d_num),
        .tx_s_num   (tx_s_num),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // requester side
    bit         pend   [N];
    logic [7:0] c_data [N];
    logic [1:0] c_par  [N];
    bit         c_d    [N];
    bit         c_s    [N];
    bit [N-1:0] auto_mask;
    bit         rand_mode;

    // timeline model
    int         cyc;
    bit         have_frame;
    int         acc_c;
    int         fl;
    int         ptr;
    logic [7:0] m_data;
    logic [1:0] m_par;
    bit         m_d;
    bit         m_s;
    int         m_id;

    int         glog[$];
    int         last_en_c;
    int         last_done_c;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic raise(input int ch, input logic [7:0] d, input logic [1:0] p,
                         input bit dn, input bit sn);
        pend[ch]   = 1'b1;
        c_data[ch] = d;
        c_par[ch]  = p;
        c_d[ch]    = dn;
        c_s[ch]    = sn;
    endtask

    task automatic model_reset();
        have_frame = 1'b0;
        ptr        = 0;
        m_data     = 8'd0;
        m_par      = 2'd0;
        m_d        = 1'b0;
        m_s        = 1'b0;
        m_id       = 0;
    endtask

    task automatic run_cycle(input bit rst_v);
        int           win;
        int           idx;
        logic [N-1:0] exp_rdy;
        bit           in_frame;
        bit           e_en;
        bit           e_done;
        @(negedge clk_tx);
        reset_n = rst_v;
        for (int i = 0; i < N; i++) begin
            if (auto_mask[i] && !pend[i] && (!rand_mode || $urandom_range(1, 0) == 1)) begin
                raise(i, 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
            end else if (rand_mode && pend[i] && $urandom_range(15, 0) == 0) begin
                pend[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_data[8*i +: 8] = c_data[i];
            req_par[2*i +: 2]  = c_par[i];
            req_d_num[i]       = c_d[i];
            req_s_num[i]       = c_s[i];
        end
        #2;
        if (!rst_v) model_reset();
        in_frame = have_frame && (cyc > acc_c) && (cyc < acc_c + 2 + fl + GAP);
        e_en     = have_frame && (cyc == acc_c + 1);
        e_done   = have_frame && (cyc == acc_c + 1 + fl);
        win = -1;
        if (rst_v && !in_frame) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (win < 0 && pend[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;

        check_val("req_ready",  req_ready,  exp_rdy);
        check_val("tx_en",      tx_en,      e_en);
        check_val("frame_done", frame_done, e_done);
        check_val("busy",       busy,       in_frame);
        check_val("tx_data",    tx_data,    m_data);
        check_val("tx_par",     tx_par,     m_par);
        check_val("tx_d_num",   tx_d_num,   m_d);
        check_val("tx_s_num",   tx_s_num,   m_s);
        check_val("grant_id",   grant_id,   m_id);

        if (tx_en === 1'b1) begin
            glog.push_back(int'(grant_id));
            last_en_c = cyc;
        end
        if (frame_done === 1'b1) last_done_c = cyc;

        if (win >= 0) begin
            have_frame = 1'b1;
            acc_c      = cyc;
            fl         = 1 + 7 + int'(c_d[win]) + ((c_par[win] == 2'd1 || c_par[win] == 2'd2) ? 1 : 0)
                         + 1 + int'(c_s[win]);
            m_data     = c_data[win];
            m_par      = c_par[win];
            m_d        = c_d[win];
            m_s        = c_s[win];
            m_id       = win;
            ptr        = (win + 1) % N;
            pend[win]  = 1'b0;
        end
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1);
    endtask

    task automatic check_glog(input string tag, input int n, input int s0, input int s1,
                              input int s2, input int s3, input int s4);
        int seq[5];
        seq = '{s0, s1, s2, s3, s4};
        check_val({tag, "_count"}, (glog.size() >= n) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < n; k++) begin
            check_val(tag, (k < glog.size()) ? glog[k] : 32'hFFFF, seq[k]);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_par     = '0;
        req_d_num   = '0;
        req_s_num   = '0;
        auto_mask   = '0;
        rand_mode   = 1'b0;
        cyc         = 0;
        acc_c       = 0;
        fl          = 0;
        last_en_c   = 0;
        last_done_c = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; c_data[i] = 8'd0; c_par[i] = 2'd0; c_d[i] = 1'b0; c_s[i] = 1'b0;
        end
        model_reset();

        // reset state
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_n(2);

        // all four channels continuously valid: 0,1,2,3,0
        glog.delete();
        auto_mask = 4'hF;
        run_n(80);
        check_glog("rr_all4", 5, 0, 1, 2, 3, 0);
        auto_mask = 4'h0;
        run_n(80);

        // single max-length frame: tx_en at t+1, frame_done at t+13
        raise(0, 8'hA5, 2'd2, 1'b1, 1'b1);
        run_n(20);
        check_val("len_max", last_done_c - last_en_c, 32'd12);

        // minimum frames, including par=3 passthrough
        raise(1, 8'h3C, 2'd0, 1'b0, 1'b0);
        run_n(15);
        check_val("len_min", last_done_c - last_en_c, 32'd9);
        raise(1, 8'hC3, 2'd3, 1'b0, 1'b0);
        run_n(15);
        check_val("len_par3", last_done_c - last_en_c, 32'd9);
        check_val("par3_out", tx_par, 32'd3);

        // ch2 arrives mid-frame of ch1 and waits
        raise(1, 8'h5A, 2'd1, 1'b1, 1'b0);
        run_n(5);
        raise(2, 8'h96, 2'd2, 1'b0, 1'b1);
        run_n(35);

        // reset during SEND cycle 5, then ch3 alone, then ch1 and ch3 together
        raise(0, 8'h77, 2'd2, 1'b1, 1'b1);
        run_n(6);
        run_cycle(1'b0);
        raise(3, 8'hE1, 2'd0, 1'b1, 1'b0);
        run_cycle(1'b0);
        run_n(16);
        raise(1, 8'h11, 2'd1, 1'b0, 1'b1);
        raise(3, 8'h33, 2'd2, 1'b1, 1'b1);
        run_n(35);

        // ch0 and ch3 continuously valid after reset: 0,3,0,3
        run_cycle(1'b0);
        run_cycle(1'b0);
        glog.delete();
        auto_mask = 4'b1001;
        run_n(70);
        check_glog("rr_0_3", 4, 0, 3, 0, 3, 0);
        auto_mask = 4'h0;
        run_n(40);

        // randomized traffic with occasional request withdrawal
        rand_mode = 1'b1;
        auto_mask = 4'hF;
        run_n(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
